// File: rtl/gfx128_pkg.sv
// Shared constants, requester indices and FSM state type
// for the gfx128 wishbone-master round-robin scheduler.
package gfx128_pkg;

  localparam int NM = 5;

  localparam int IDX_CLIP     = 0;
  localparam int IDX_FRAGMENT = 1;
  localparam int IDX_BLENDER  = 2;
  localparam int IDX_TEXTBLIT = 3;
  localparam int IDX_WRITER   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

  function automatic logic [2:0] oh2idx(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gfx128_rr_pick.sv
// Combinational round-robin picker: searches last+1 .. last
// (modulo NM) and returns the first requester as a one-hot winner.
module gfx128_rr_pick #(
  parameter int NM = 5
) (
  input  logic [NM-1:0] req,
  input  logic [2:0]    last,
  output logic [NM-1:0] win,
  output logic          valid
);

  // Walk farthest-first so the nearest hit overwrites the rest.
  always_comb begin
    win = '0;
    for (int k = NM; k >= 1; k--) begin
      if (req[(int'(last) + k) % NM]) begin
        win = '0;
        win[(int'(last) + k) % NM] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/gfx128_wbm_rr_scheduler.sv
// Round-robin scheduler that shares one wishbone master engine
// between the gfx128 clip/fragment/blender/textblit/writer units.
module gfx128_wbm_rr_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int NM      = gfx128_pkg::NM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NM-1:0]        req_i,
  input  logic [NM-1:0][31:4]  addr_i,
  input  logic [NM-1:0][15:0]  sel_i,
  input  logic [127:0]         wdat_i,
  output logic                 read_request_o,
  output logic                 write_request_o,
  output logic [31:4]          addr_o,
  output logic [15:0]          sel_o,
  output logic                 we_o,
  output logic [127:0]         dat_o,
  input  logic [127:0]         dat_i,
  input  logic                 ack_i,
  output logic [127:0]         rdat_o,
  output logic [NM-1:0]        ack_o,
  output logic [NM-1:0]        err_o,
  output logic [NM-1:0]        grant_o,
  output logic                 busy_o
);

  import gfx128_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [NM-1:0] grant, grant_nx;
  logic [2:0]    last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NM-1:0] win;
  logic          win_vld;
  logic          in_grant;
  logic          gnt_req;
  logic          tmo;
  logic [31:4]   addr_mux;
  logic [15:0]   sel_mux;

  gfx128_rr_pick #(
    .NM (NM)
  ) u_pick (
    .req   (req_i),
    .last  (last),
    .win   (win),
    .valid (win_vld)
  );

  assign in_grant = (state == ST_GRANT);
  assign gnt_req  = |(grant & req_i);
  assign tmo      = in_grant && !ack_i && gnt_req
                    && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= 3'(NM - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_nx = ST_GRANT;
          grant_nx = win;
          last_nx  = oh2idx(8'(win));
          cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        // Ack, requester withdrawal and timeout all close the grant.
        if (ack_i || !gnt_req || tmo) begin
          state_nx = ST_GAP;
          grant_nx = '0;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_comb begin
    addr_mux = '0;
    sel_mux  = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) begin
        addr_mux |= addr_i[i];
        sel_mux  |= sel_i[i];
      end
    end
  end

  assign write_request_o = in_grant && grant[IDX_WRITER];
  assign read_request_o  = in_grant && !grant[IDX_WRITER];
  assign we_o            = write_request_o;
  assign addr_o          = in_grant ? addr_mux : '0;
  assign sel_o           = in_grant ? sel_mux : '0;
  assign dat_o           = wdat_i;
  assign rdat_o          = dat_i;

  assign ack_o   = (ack_i && in_grant) ? grant : '0;
  assign err_o   = tmo ? grant : '0;
  assign grant_o = grant;
  assign busy_o  = |req_i;

endmodule

// File: tb/tb_gfx128_wbm_rr_scheduler.sv
// Directed bench for the gfx128 round-robin wishbone scheduler,
// built with TIMEOUT=8 so the abort path is reachable quickly.
module tb_gfx128_wbm_rr_scheduler;

  localparam int NM = 5;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [NM-1:0]       req_i;
  logic [NM-1:0][31:4] addr_i;
  logic [NM-1:0][15:0] sel_i;
  logic [127:0]        wdat_i;
  logic                read_request_o;
  logic                write_request_o;
  logic [31:4]         addr_o;
  logic [15:0]         sel_o;
  logic                we_o;
  logic [127:0]        dat_o;
  logic [127:0]        dat_i;
  logic                ack_i;
  logic [127:0]        rdat_o;
  logic [NM-1:0]       ack_o;
  logic [NM-1:0]       err_o;
  logic [NM-1:0]       grant_o;
  logic                busy_o;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  gfx128_wbm_rr_scheduler #(
    .TIMEOUT (8),
    .NM      (NM)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .addr_i          (addr_i),
    .sel_i           (sel_i),
    .wdat_i          (wdat_i),
    .read_request_o  (read_request_o),
    .write_request_o (write_request_o),
    .addr_o          (addr_o),
    .sel_o           (sel_o),
    .we_o            (we_o),
    .dat_o           (dat_o),
    .dat_i           (dat_i),
    .ack_i           (ack_i),
    .rdat_o          (rdat_o),
    .ack_o           (ack_o),
    .err_o           (err_o),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NM-1:0] g;
    int            idx;

    rst_ni = 1'b0;
    req_i  = '0;
    addr_i = '0;
    sel_i  = '0;
    wdat_i = '0;
    dat_i  = 128'h1234_5678;
    ack_i  = 1'b0;
    #12;
    chk("rst_grant", grant_o, 5'b00000);
    chk("rst_rd", read_request_o, 1'b0);
    chk("rst_busy0", busy_o, 1'b0);
    chk("rdat", rdat_o, 128'h1234_5678);
    req_i = 5'b00100;
    ack_i = 1'b1;
    #1;
    chk("rst_busy1", busy_o, 1'b1);
    chk("rst_ack", ack_o, 5'b00000);
    req_i = '0;
    ack_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // single blender read
    cyc();
    req_i = 5'b00100;
    #1;
    chk("t1_idle_grant", grant_o, 5'b00000);
    cyc();
    #1;
    chk("t1_grant", grant_o, 5'b00100);
    chk("t1_rd", read_request_o, 1'b1);
    chk("t1_we", we_o, 1'b0);
    chk("t1_wr", write_request_o, 1'b0);
    chk("t1_noack", ack_o, 5'b00000);
    cyc();
    ack_i = 1'b1;
    #1;
    chk("t1_ack", ack_o, 5'b00100);
    chk("t1_err", err_o, 5'b00000);
    cyc();
    req_i = '0;
    #1;
    chk("t1_gap_grant", grant_o, 5'b00000);
    chk("t1_gap_ack", ack_o, 5'b00000);
    chk("t1_gap_rd", read_request_o, 1'b0);
    cyc();
    ack_i = 1'b0;
    #1;
    chk("t1_idle", grant_o, 5'b00000);

    // full round robin after a fresh reset
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    cyc();
    req_i = 5'b11111;
    ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idx = i % 5;
      g   = 5'b00001 << idx;
      cyc();
      #1;
      chk("t2_grant", grant_o, g);
      chk("t2_wr", write_request_o, idx == 4);
      chk("t2_we", we_o, idx == 4);
      chk("t2_rd", read_request_o, idx != 4);
      chk("t2_ack", ack_o, g);
      cyc();
      chk("t2_gap", grant_o, 5'b00000);
      cyc();
      chk("t2_idle", grant_o, 5'b00000);
    end
    req_i = '0;
    ack_i = 1'b0;

    // writer datapath
    addr_i[4] = 28'h0000123;
    addr_i[0] = 28'hABCDEF0;
    sel_i[4]  = 16'hFFFF;
    sel_i[0]  = 16'h00F0;
    wdat_i    = {16{8'hA5}};
    req_i     = 5'b10000;
    cyc();
    #1;
    chk("t3_grant", grant_o, 5'b10000);
    chk("t3_addr", addr_o, 28'h0000123);
    chk("t3_sel", sel_o, 16'hFFFF);
    chk("t3_dat", dat_o, {16{8'hA5}});
    chk("t3_wr", write_request_o, 1'b1);
    chk("t3_rd", read_request_o, 1'b0);
    chk("t3_we", we_o, 1'b1);
    ack_i = 1'b1;
    #1;
    chk("t3_ack", ack_o, 5'b10000);
    cyc();
    ack_i = 1'b0;
    req_i = '0;
    #1;
    chk("t3_gap_addr", addr_o, 28'h0);
    chk("t3_gap_sel", sel_o, 16'h0);
    chk("t3_gap_wr", write_request_o, 1'b0);
    cyc();

    // timeout on requester 0, then requester 1 is next
    req_i = 5'b00011;
    cyc();
    #1;
    chk("t4_grant", grant_o, 5'b00001);
    for (int k = 0; k < 8; k++) begin
      chk("t4_early_err", err_o, 5'b00000);
      cyc();
      #1;
    end
    chk("t4_err", err_o, 5'b00001);
    chk("t4_noack", ack_o, 5'b00000);
    cyc();
    #1;
    chk("t4_gap_err", err_o, 5'b00000);
    chk("t4_gap", grant_o, 5'b00000);
    cyc();
    cyc();
    #1;
    chk("t4_next", grant_o, 5'b00010);

    // ack coincident with timeout
    for (int k = 0; k < 8; k++) cyc();
    ack_i = 1'b1;
    #1;
    chk("t5_ack", ack_o, 5'b00010);
    chk("t5_err", err_o, 5'b00000);
    cyc();
    ack_i = 1'b0;
    req_i = 5'b00001;
    #1;
    chk("t5_gap", grant_o, 5'b00000);
    cyc();
    cyc();
    #1;
    chk("t5_grant0", grant_o, 5'b00001);
    req_i = '0;
    #1;
    chk("t5_drop_ack", ack_o, 5'b00000);
    chk("t5_drop_err", err_o, 5'b00000);
    cyc();
    #1;
    chk("t5_drop_gap", grant_o, 5'b00000);
    chk("t5_drop_rd", read_request_o, 1'b0);
    cyc();

    // reset in the middle of a grant
    req_i = 5'b00100;
    cyc();
    #1;
    chk("t6_grant", grant_o, 5'b00100);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_grant", grant_o, 5'b00000);
    chk("t6_rst_rd", read_request_o, 1'b0);
    ack_i = 1'b1;
    #1;
    chk("t6_rst_ack", ack_o, 5'b00000);
    chk("t6_rst_err", err_o, 5'b00000);
    chk("t6_rst_busy", busy_o, 1'b1);
    ack_i = 1'b0;
    req_i = 5'b10001;
    #2;
    rst_ni = 1'b1;
    cyc();
    #1;
    chk("t6_first", grant_o, 5'b00001);
    ack_i = 1'b1;
    #1;
    chk("t6_ack", ack_o, 5'b00001);
    cyc();
    ack_i = 1'b0;
    req_i = '0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
